// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC command sequencer.
// Optional timeout support is enabled with ADC_CMD_SEQ_TIMEOUT_EN.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP,
    S_WAIT_TICK
  } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample tick divider.
// Counter is parked at 0 whenever enable is low.
module sample_tick_gen #(
  parameter int CLK_DIV = 3125
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/adc_cmd_seq.sv
// Periodic Avalon-ST command issuer and response capture for an ADC core.
// Define ADC_CMD_SEQ_TIMEOUT_EN to add the response timeout.
module adc_cmd_seq
  import adc_pkg::*;
#(
  parameter int                  CLK_DIV        = 3125,
  parameter logic [ADC_CH_W-1:0] CHANNEL        = 5'd1,
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  command_valid,
  output logic                  command_startofpacket,
  output logic                  command_endofpacket,
  output logic [ADC_CH_W-1:0]   command_channel,
  input  logic                  command_ready,
  input  logic                  response_valid,
  input  logic [ADC_CH_W-1:0]   response_channel,
  input  logic [ADC_DATA_W-1:0] response_data,
  output logic [ADC_DATA_W-1:0] sample_data,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  timeout_err,
  output logic                  busy
);

  seq_state_t state_q, state_d;
  logic tick, en_q, en_rise;
  logic resp_hit, capture, to_expire, to_fire;

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign en_rise  = enable && !en_q;
  assign resp_hit = response_valid &&
                    (response_channel == CHANNEL);
  assign busy     = (state_q == S_ISSUE) ||
                    (state_q == S_WAIT_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    to_fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (command_ready) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (resp_hit) begin
          capture = 1'b1;
          state_d = enable ? S_WAIT_TICK : S_IDLE;
        end else if (to_expire) begin
          to_fire = 1'b1;
          state_d = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command outputs are pure decodes of state so reset drops them at once.
  assign command_valid         = (state_q == S_ISSUE);
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign command_channel       = command_valid ? CHANNEL : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      en_q         <= enable;
      sample_valid <= capture;
      if (capture) sample_data <= response_data;
      if (en_rise)   overrun <= 1'b0;
      else if (tick && busy) overrun <= 1'b1;
    end
  end

`ifdef ADC_CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == S_WAIT_RESP) to_cnt <= to_cnt + TW'(1);
      else                        to_cnt <= '0;
      if (en_rise)      timeout_err <= 1'b0;
      else if (to_fire) timeout_err <= 1'b1;
    end
  end

  assign to_expire = (state_q == S_WAIT_RESP) &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;

  assign unused_to   = (TIMEOUT_CYCLES > 0) ^ to_fire;
  assign to_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_cmd_seq.sv
// Directed bench for adc_cmd_seq with CLK_DIV=8, CHANNEL=1.
// Timeout sequence follows ADC_CMD_SEQ_TIMEOUT_EN.
module tb_adc_cmd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        command_ready = 1'b0;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = '0;
  logic [11:0] response_data = '0;
  logic        command_valid, command_startofpacket;
  logic        command_endofpacket;
  logic [4:0]  command_channel;
  logic [11:0] sample_data;
  logic        sample_valid, overrun, timeout_err, busy;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic        en, rdy, rv;
    logic [4:0]  ch;
    logic [11:0] d;
    logic        cv, bsy, sv, ov;
    logic [11:0] sd;
  } vec_t;

  vec_t tbl [21];

  adc_cmd_seq #(
    .CLK_DIV        (8),
    .CHANNEL        (5'd1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .command_valid         (command_valid),
    .command_startofpacket (command_startofpacket),
    .command_endofpacket   (command_endofpacket),
    .command_channel       (command_channel),
    .command_ready         (command_ready),
    .response_valid        (response_valid),
    .response_channel      (response_channel),
    .response_data         (response_data),
    .sample_data           (sample_data),
    .sample_valid          (sample_valid),
    .overrun               (overrun),
    .timeout_err           (timeout_err),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic en, logic rdy, logic rv,
    logic [4:0] ch, logic [11:0] d,
    logic cv, logic bsy, logic sv, logic ov,
    logic [11:0] sd);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv;
    v.ch = ch; v.d = d;
    v.cv = cv; v.bsy = bsy; v.sv = sv;
    v.ov = ov; v.sd = sd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Inputs change on the falling edge; outputs sampled 1 time unit later.
  task automatic cyc(input logic en, input logic rdy,
                     input logic rv, input logic [4:0] ch,
                     input logic [11:0] d);
    @(negedge clk);
    enable           = en;
    command_ready    = rdy;
    response_valid   = rv;
    response_channel = ch;
    response_data    = d;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b1, rdy, 1'b0, 5'd0, 12'h000);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cv"},  command_valid, 0);
    chk({tag, " sop"}, command_startofpacket, 0);
    chk({tag, " eop"}, command_endofpacket, 0);
    chk({tag, " ch"},  command_channel, 0);
    chk({tag, " sd"},  sample_data, 0);
    chk({tag, " sv"},  sample_valid, 0);
    chk({tag, " ov"},  overrun, 0);
    chk({tag, " to"},  timeout_err, 0);
    chk({tag, " bsy"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 12'h000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ncmd, nxfer, ncv, n;

    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1,1,0,0,0,   0,0,0,0,0);
    tbl[8]  = mk(1,1,0,0,0,    1,1,0,0,0);
    tbl[9]  = mk(1,1,0,0,0,    0,1,0,0,0);
    tbl[10] = mk(1,1,0,0,0,    0,1,0,0,0);
    tbl[11] = mk(1,1,1,1,'hABC, 0,1,0,0,0);
    tbl[12] = mk(1,1,0,0,0,    0,0,1,0,'hABC);
    tbl[13] = mk(1,1,1,1,'hFFF, 0,0,0,0,'hABC);
    tbl[14] = mk(1,1,0,0,0,    0,0,0,0,'hABC);
    tbl[15] = mk(1,1,0,0,0,    0,0,0,0,'hABC);
    tbl[16] = mk(1,1,0,0,0,    1,1,0,0,'hABC);
    tbl[17] = mk(1,1,1,2,'h555, 0,1,0,0,'hABC);
    tbl[18] = mk(1,1,1,1,'h123, 0,1,0,0,'hABC);
    tbl[19] = mk(1,1,0,0,0,    0,0,1,0,'h123);
    tbl[20] = mk(1,1,0,0,0,    0,0,0,0,'h123);

    // Periodic issue, capture, wrong channel and stray responses.
    do_reset();
    chk_reset_vals("rst0");
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].en, tbl[i].rdy, tbl[i].rv,
          tbl[i].ch, tbl[i].d);
      chk($sformatf("v%0d cv", i), command_valid, tbl[i].cv);
      chk($sformatf("v%0d bsy", i), busy, tbl[i].bsy);
      chk($sformatf("v%0d sv", i), sample_valid, tbl[i].sv);
      chk($sformatf("v%0d ov", i), overrun, tbl[i].ov);
      chk($sformatf("v%0d sd", i), sample_data, tbl[i].sd);
      if (tbl[i].cv) begin
        chk($sformatf("v%0d sop", i),
            command_startofpacket, 1);
        chk($sformatf("v%0d eop", i),
            command_endofpacket, 1);
        chk($sformatf("v%0d chn", i), command_channel, 1);
      end
    end

    // Backpressure: ready low 5 cycles, enable falls mid-wait.
    do_reset();
    n = 0;
    idle(1'b0);
    while (!command_valid && n < 20) begin
      idle(1'b0);
      n++;
    end
    chk("bp first cv", command_valid, 1);
    chk("bp first vec", n, 8);
    ncv = 1; nxfer = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) idle(1'b0);
      else if (i == 3) cyc(1'b0, 1'b0, 1'b0, 5'd0, 12'h000);
      else cyc(1'b0, 1'b1, 1'b0, 5'd0, 12'h000);
      if (command_valid) ncv++;
      if (command_valid && command_ready) nxfer++;
    end
    chk("bp cv cycles", ncv, 6);
    chk("bp transfers", nxfer, 1);
    cyc(1'b0, 1'b0, 1'b1, 5'd1, 12'h2A5);
    chk("bp wait cv", command_valid, 0);
    chk("bp wait bsy", busy, 1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 12'h000);
    chk("bp sv", sample_valid, 1);
    chk("bp sd", sample_data, 12'h2A5);
    chk("bp ov", overrun, 0);
    chk("bp idle bsy", busy, 0);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 12'h000);
    chk("bp idle cv", command_valid, 0);

    // Slow response: second tick lands in WAIT_RESP.
    do_reset();
    ncmd = 0;
    for (int v = 0; v < 23; v++) begin
      if (v == 18) cyc(1'b1, 1'b1, 1'b1, 5'd1, 12'h0F0);
      else idle(1'b1);
      if (command_valid) ncmd++;
      if (v == 15) chk("slow ov pre", overrun, 0);
      if (v == 16) chk("slow ov set", overrun, 1);
      if (v == 19) begin
        chk("slow sv", sample_valid, 1);
        chk("slow sd", sample_data, 12'h0F0);
      end
    end
    chk("slow one cmd", ncmd, 1);
    idle(1'b1);
    idle(1'b1);
    chk("slow next cmd", command_valid, 1);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 12'h000);
    chk("slow ov fall", overrun, 1);
    idle(1'b1);
    chk("slow ov rise", overrun, 1);
    idle(1'b1);
    chk("slow ov clr", overrun, 0);

    // Response and tick together, then async reset mid-ISSUE.
    do_reset();
    for (int v = 0; v < 15; v++) idle(1'b1);
    cyc(1'b1, 1'b1, 1'b1, 5'd1, 12'h3C3);
    idle(1'b1);
    chk("same sv", sample_valid, 1);
    chk("same sd", sample_data, 12'h3C3);
    chk("same ov", overrun, 1);
    chk("same bsy", busy, 0);
    ncmd = 0;
    for (int v = 17; v < 24; v++) begin
      idle(1'b1);
      if (command_valid) ncmd++;
    end
    chk("same no reuse", ncmd, 0);
    idle(1'b0);
    chk("same next cmd", command_valid, 1);
    chk("pre-rst ov", overrun, 1);
    chk("pre-rst sd", sample_data, 12'h3C3);
    #1 reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    reset = 1'b0;

    // Response timeout.
    do_reset();
    for (int v = 0; v < 25; v++) idle(1'b1);
    chk("to v24 err", timeout_err, 0);
    chk("to v24 bsy", busy, 1);
    idle(1'b1);
`ifdef ADC_CMD_SEQ_TIMEOUT_EN
    chk("to err", timeout_err, 1);
    chk("to bsy", busy, 0);
    chk("to sv", sample_valid, 0);
    for (int v = 26; v < 33; v++) idle(1'b1);
    chk("to reissue", command_valid, 1);
`else
    chk("to err off", timeout_err, 0);
    chk("to bsy hold", busy, 1);
    for (int v = 26; v < 60; v++) idle(1'b1);
    chk("to wait on", busy, 1);
    chk("to no cmd", command_valid, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/adc_cmd_seq.md
ADC_CMD_SEQ -- requirements
Module: adc_cmd_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3125, clk cycles between sample ticks (16 kHz at 50 MHz).
REQ-002 SHALL have parameter CHANNEL, default 1, ADC channel requested, 5 bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, max clk cycles waiting for a response.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  high = issue one conversion per tick.
REQ-007 SHALL have ports command_valid/command_startofpacket/command_endofpacket  out  1  Avalon-ST command to ADC core.
REQ-008 SHALL have port command_channel  out  5  equals CHANNEL.
REQ-009 SHALL have port command_ready  in  1  ADC core accepts command.
REQ-010 SHALL have ports response_valid  in  1, response_channel  in  5, response_data  in  12  ADC result.
REQ-011 SHALL have ports sample_data  out  12, sample_valid  out  1  captured sample, 1-cycle strobe.
REQ-012 SHALL have ports overrun  out  1, timeout_err  out  1, busy  out  1  status.

Function
REQ-013 SHALL run a tick counter 0..CLK_DIV-1 while enable=1; tick = counter at CLK_DIV-1; counter held at 0 while enable=0.
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT_RESP, WAIT_TICK.
REQ-015 IDLE/WAIT_TICK: tick with enable=1 -> ISSUE; WAIT_TICK with enable=0 -> IDLE.
REQ-016 ISSUE: command_valid, startofpacket, endofpacket = 1; transfer on command_valid&command_ready same cycle; then -> WAIT_RESP.
REQ-017 command_valid SHALL NOT deassert before acceptance, even if enable falls.
REQ-018 WAIT_RESP: response_valid with response_channel==CHANNEL -> sample_data<=response_data, sample_valid=1 next cycle only, -> WAIT_TICK (or IDLE if enable=0).
REQ-019 response_valid with other channel, or outside WAIT_RESP, SHALL be ignored.
REQ-020 tick arriving in ISSUE or WAIT_RESP SHALL set overrun (sticky) and SHALL NOT queue a second command.
REQ-021 overrun and timeout_err SHALL clear on reset or on enable rising edge only.
REQ-022 busy SHALL be 1 in ISSUE and WAIT_RESP, else 0.
REQ-023 sample_data SHALL hold last value until next valid response.
REQ-024 response and tick in same cycle in WAIT_RESP: response captured, overrun set, next state WAIT_TICK (tick not reused).

Reset
REQ-025 reset SHALL force state IDLE, counters 0, all command outputs 0, sample_data 0, sample_valid 0, overrun 0, timeout_err 0, busy 0.
REQ-026 reset mid-ISSUE SHALL drop command_valid immediately (asynchronously).

Configuration
REQ-027 With ADC_CMD_SEQ_TIMEOUT_EN defined: counter in WAIT_RESP; reaching TIMEOUT_CYCLES sets timeout_err (sticky), -> WAIT_TICK, no sample_valid.
REQ-028 Without ADC_CMD_SEQ_TIMEOUT_EN: no timeout counter, timeout_err tied 0, WAIT_RESP waits indefinitely.

Structure
REQ-029 Package adc_pkg SHALL hold FSM state typedef, ADC_DATA_W=12, ADC_CH_W=5.
REQ-030 Sub-module sample_tick_gen SHALL implement REQ-013 (inputs clk, reset, enable; output tick).

Verification
REQ-031 CLK_DIV=8, ready=1, response 0xABC ch1 3 cycles after accept -> sample_data=0xABC, sample_valid 1 cycle, command every 8 cycles.
REQ-032 command_ready low 5 cycles -> command_valid held 5+1 cycles, one transfer, no overrun.
REQ-033 CLK_DIV=8, response delayed 10 cycles -> overrun=1, exactly one command issued for two ticks.
REQ-034 Response on ch2 then ch1 value 0x123 -> only 0x123 captured.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=16, no response -> timeout_err=1 at cycle 16, state WAIT_TICK, next tick issues new command.
REQ-036 reset asserted in ISSUE -> command_valid 0 same cycle, all outputs at reset values.
